// File: rtl/sign_mag_converter.sv
// rtl/sign_mag_converter.sv - bit-serial two's/ones' complement to sign-magnitude converter
module sign_mag_converter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mag,
    output logic             neg,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q;
    logic             mode_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             last_bit;
    logic             a_bit;
    logic             inv_bit;
    logic             sum_bit;
    logic [WIDTH-1:0] mag_final;

    // Positive operands pass straight through: inversion off and carry was loaded as 0.
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign a_bit     = a_q[cnt];
    assign inv_bit   = a_q[WIDTH-1] ? ~a_bit : a_bit;
    assign sum_bit   = inv_bit ^ carry;
    assign mag_final = {sum_bit, mag[WIDTH-2:0]};

    assign busy = (state == CONV);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
            carry  <= 1'b0;
            mag    <= '0;
            neg    <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        mode_q <= mode;
                        cnt    <= '0;
                        carry  <= a[WIDTH-1] & ~mode;
                    end
                end
                CONV: begin
                    mag[cnt] <= sum_bit;
                    carry    <= inv_bit & carry;
                    if (last_bit) begin
                        cnt  <= '0;
                        // Only ones'-complement negative zero yields a negative operand with mag 0.
                        neg  <= a_q[WIDTH-1] & (mag_final != '0);
                        zero <= (mag_final == '0);
                        ovf  <= ~mode_q & (a_q == {1'b1, {(WIDTH-1){1'b0}}});
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sign_mag_converter.md
SIGN_MAG_CONVERTER -- requirements
Module: sign_mag_converter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result width in bits, legal range 2..32.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request conversion; sampled only in IDLE.
REQ-006 Port: mode  input  1  0 = operand is two's complement, 1 = operand is ones' complement; captured with start.
REQ-007 Port: a  input  WIDTH  signed operand; captured with start.
REQ-008 Port: busy  output  1  high while a conversion is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; result outputs valid from this cycle on.
REQ-010 Port: mag  output  WIDTH  unsigned magnitude of captured operand.
REQ-011 Port: neg  output  1  result sign, 1 = negative.
REQ-012 Port: zero  output  1  high when mag == 0.
REQ-013 Port: ovf  output  1  high when the magnitude does not fit in WIDTH-1 bits (two's-complement most-negative value).

Function
REQ-014 FSM states SHALL be IDLE, CONV, DONE; encoding free.
REQ-015 IDLE: start = 1 at an edge SHALL capture a, mode into internal registers, clear bit counter, load serial carry, go to CONV; start = 0 stays IDLE.
REQ-016 Conversion SHALL be bit-serial, one bit per clock, LSB first, through a single 1-bit adder stage and a 1-bit carry register.
REQ-017 Positive operand (captured MSB = 0): mag bit i SHALL equal a[i] (carry/inversion disabled).
REQ-018 Negative operand (captured MSB = 1): mag bit i SHALL equal (~a[i]) XOR c, next c = (~a[i]) AND c; initial c = 1 when mode = 0, c = 0 when mode = 1.
REQ-019 CONV SHALL last exactly WIDTH cycles (bits 0..WIDTH-1, counter wraps to 0 at exit), then go to DONE.
REQ-020 Latency: start sampled at edge k SHALL give done = 1 and valid mag/neg/zero/ovf during the cycle after edge k+WIDTH; DONE lasts one cycle, returns to IDLE after edge k+WIDTH+1.
REQ-021 busy SHALL be 1 in CONV only; done SHALL be 1 in DONE only; never both.
REQ-022 start SHALL be ignored in CONV and DONE; no queuing; a and mode changes there SHALL not affect the result.
REQ-023 mag, neg, zero, ovf SHALL hold their last values from DONE until the next DONE; mag MAY update bit-serially during CONV but SHALL be complete by DONE.
REQ-024 neg SHALL equal captured MSB, except mode = 1 with operand all ones (negative zero): mag = 0, neg = 0.
REQ-025 ovf SHALL be 1 only when mode = 0 and operand = 1 followed by WIDTH-1 zeros; mag then = same pattern (2^(WIDTH-1)), neg = 1.
REQ-026 zero SHALL be 1 exactly when final mag is all zeros (operand 0 in either mode, or ones'-complement negative zero).

Reset
REQ-027 rst = 1 at an edge SHALL force IDLE, busy = 0, done = 0, mag = 0, neg = 0, zero = 0, ovf = 0, counter = 0, carry = 0, taking priority over start.
REQ-028 rst asserted during CONV or DONE SHALL abort the conversion with no done pulse; next conversion needs a fresh start after rst deasserts.

Verification (WIDTH = 8)
REQ-029 mode 0, a = 0x05, start at edge k -> busy edges k+1..k+8, done one cycle after edge k+8, mag 0x05, neg 0, zero 0, ovf 0.
REQ-030 mode 0, a = 0xFB -> mag 0x05, neg 1, ovf 0; mode 1, a = 0xFA -> mag 0x05, neg 1.
REQ-031 mode 0, a = 0x80 -> mag 0x80, neg 1, ovf 1; mode 1, a = 0x80 -> mag 0x7F, neg 1, ovf 0.
REQ-032 mode 1, a = 0xFF -> mag 0x00, neg 0, zero 1; mode 0, a = 0x00 -> mag 0x00, neg 0, zero 1.
REQ-033 start pulsed with a = 0x01 at 3rd CONV cycle of an a = 0xFE (mode 0) conversion -> ignored, result mag 0x02, neg 1, exactly one done pulse.
REQ-034 rst at 4th CONV cycle -> next cycle IDLE, all outputs 0, no done; new start then completes normally.
